// File: rtl/la_sram_sequencer.sv
// Sequencer for the two SQI sample SRAMs: WRITE-header + sample streaming on capture,
// READ-header + dummy clocks + host-stepped nibble fetch on readback.
module la_sram_sequencer #(
  parameter int LA_WIDTH     = 8,
  parameter int CNT_WIDTH    = 23,
  parameter int ADDR_NIBBLES = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cap_start,
  input  logic                 rd_start,
  input  logic                 rd_step,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] samples_post,
  input  logic [LA_WIDTH-1:0]  la_data,
  input  logic [LA_WIDTH-1:0]  sio_in,
  output logic [LA_WIDTH-1:0]  sio_out,
  output logic                 sio_oe,
  output logic                 sram_cs_n,
  output logic                 sram_clk_en,
  output logic [LA_WIDTH-1:0]  rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 cap_done,
  output logic [CNT_WIDTH-1:0] sample_count
);

  localparam int NIB  = LA_WIDTH / 4;
  localparam int PH_W = (ADDR_NIBBLES > 2) ? $clog2(ADDR_NIBBLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_W_CMD, S_W_ADDR, S_CAPTURE, S_W_END,
    S_R_CMD, S_R_ADDR, S_R_DUMMY, S_R_WAIT, S_R_CLK, S_R_SAMPLE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [PH_W-1:0]      r_ph, w_ph_nxt;
  logic [CNT_WIDTH-1:0] r_lim, w_lim_nxt;
  logic [CNT_WIDTH-1:0] r_sample_count, w_cnt_nxt;
  logic [LA_WIDTH-1:0]  r_sio_out, w_sio_nxt;
  logic [LA_WIDTH-1:0]  r_rd_data, w_rd_data_nxt;
  logic                 r_sio_oe, w_oe_nxt;
  logic                 r_cs_n, w_cs_n_nxt;
  logic                 r_clk_en, w_clk_en_nxt;
  logic                 r_rd_valid, w_rd_valid_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_cap_done, w_cap_done_nxt;
  logic                 w_ph_last_cmd, w_ph_last_addr, w_last_sample;

  assign w_ph_last_cmd  = (r_ph == PH_W'(1));
  assign w_ph_last_addr = (r_ph == PH_W'(ADDR_NIBBLES - 1));
  // In CAPTURE the count already includes the sample on the pins, so compare one back.
  assign w_last_sample  = ((r_sample_count - CNT_WIDTH'(1)) == r_lim);

  always_comb begin
    w_state_nxt    = r_state;
    w_ph_nxt       = r_ph;
    w_lim_nxt      = r_lim;
    w_cnt_nxt      = r_sample_count;
    w_cap_done_nxt = r_cap_done;
    w_rd_data_nxt  = r_rd_data;
    w_sio_nxt      = '0;
    w_oe_nxt       = 1'b0;
    w_cs_n_nxt     = 1'b1;
    w_clk_en_nxt   = 1'b0;
    w_rd_valid_nxt = 1'b0;

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cap_start) begin
            w_state_nxt    = S_W_CMD;
            w_ph_nxt       = '0;
            w_lim_nxt      = samples_post;
            w_cnt_nxt      = '0;
            w_cap_done_nxt = 1'b0;
          end else if (rd_start) begin
            w_state_nxt    = S_R_CMD;
            w_ph_nxt       = '0;
            w_cap_done_nxt = 1'b0;
          end
        end
        S_W_CMD: begin
          if (w_ph_last_cmd) begin
            w_state_nxt = S_W_ADDR;
            w_ph_nxt    = '0;
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        S_W_ADDR: begin
          if (w_ph_last_addr) begin
            w_state_nxt = S_CAPTURE;
            w_ph_nxt    = '0;
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        S_CAPTURE:  if (w_last_sample) w_state_nxt = S_W_END;
        S_W_END:    w_state_nxt = S_IDLE;
        S_R_CMD: begin
          if (w_ph_last_cmd) begin
            w_state_nxt = S_R_ADDR;
            w_ph_nxt    = '0;
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        S_R_ADDR: begin
          if (w_ph_last_addr) begin
            w_state_nxt = S_R_DUMMY;
            w_ph_nxt    = '0;
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        S_R_DUMMY: begin
          if (w_ph_last_cmd) begin
            w_state_nxt = S_R_WAIT;
            w_ph_nxt    = '0;
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        S_R_WAIT:   if (rd_step) w_state_nxt = S_R_CLK;
        S_R_CLK:    w_state_nxt = S_R_SAMPLE;
        S_R_SAMPLE: w_state_nxt = S_R_WAIT;
        default:    w_state_nxt = S_IDLE;
      endcase
    end

    // Pin values are decoded from the state being entered so they register with it.
    case (w_state_nxt)
      S_W_CMD, S_R_CMD: begin
        w_cs_n_nxt   = 1'b0;
        w_oe_nxt     = 1'b1;
        w_clk_en_nxt = 1'b1;
        if (w_ph_nxt == PH_W'(1))
          w_sio_nxt = (w_state_nxt == S_W_CMD) ? {NIB{4'h2}} : {NIB{4'h3}};
      end
      S_W_ADDR, S_R_ADDR: begin
        w_cs_n_nxt   = 1'b0;
        w_oe_nxt     = 1'b1;
        w_clk_en_nxt = 1'b1;
      end
      S_CAPTURE: begin
        w_cs_n_nxt   = 1'b0;
        w_oe_nxt     = 1'b1;
        w_clk_en_nxt = 1'b1;
        w_sio_nxt    = la_data;
        w_cnt_nxt    = r_sample_count + CNT_WIDTH'(1);
      end
      S_W_END:   w_cap_done_nxt = 1'b1;
      S_R_DUMMY, S_R_CLK: begin
        w_cs_n_nxt   = 1'b0;
        w_clk_en_nxt = 1'b1;
      end
      S_R_WAIT:  w_cs_n_nxt = 1'b0;
      S_R_SAMPLE: begin
        w_cs_n_nxt     = 1'b0;
        w_rd_data_nxt  = sio_in;
        w_rd_valid_nxt = 1'b1;
      end
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_ph           <= '0;
      r_lim          <= '0;
      r_sample_count <= '0;
      r_sio_out      <= '0;
      r_rd_data      <= '0;
      r_sio_oe       <= 1'b0;
      r_cs_n         <= 1'b1;
      r_clk_en       <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_busy         <= 1'b0;
      r_cap_done     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ph           <= w_ph_nxt;
      r_lim          <= w_lim_nxt;
      r_sample_count <= w_cnt_nxt;
      r_sio_out      <= w_sio_nxt;
      r_rd_data      <= w_rd_data_nxt;
      r_sio_oe       <= w_oe_nxt;
      r_cs_n         <= w_cs_n_nxt;
      r_clk_en       <= w_clk_en_nxt;
      r_rd_valid     <= w_rd_valid_nxt;
      r_busy         <= w_busy_nxt;
      r_cap_done     <= w_cap_done_nxt;
    end
  end

  assign sio_out      = r_sio_out;
  assign sio_oe       = r_sio_oe;
  assign sram_cs_n    = r_cs_n;
  assign sram_clk_en  = r_clk_en;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign busy         = r_busy;
  assign cap_done     = r_cap_done;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_la_sram_sequencer.sv
// Bench for la_sram_sequencer: per-cycle expected pin table built from the protocol rules,
// a two-chip SQI SRAM read model, and literal spot checks.
module tb_la_sram_sequencer;

  localparam int CW = 23;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          cap_start, rd_start, rd_step, abort;
  logic [CW-1:0] samples_post;
  logic [7:0]    la_data, sio_in;
  logic [7:0]    sio_out, rd_data;
  logic          sio_oe, sram_cs_n, sram_clk_en, rd_valid, busy, cap_done;
  logic [CW-1:0] sample_count;

  la_sram_sequencer #(.LA_WIDTH(8), .CNT_WIDTH(CW), .ADDR_NIBBLES(6)) dut (
    .clock(clock), .reset_n(reset_n), .cap_start(cap_start), .rd_start(rd_start),
    .rd_step(rd_step), .abort(abort), .samples_post(samples_post), .la_data(la_data),
    .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe), .sram_cs_n(sram_cs_n),
    .sram_clk_en(sram_clk_en), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .cap_done(cap_done), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          cs_n;
    logic          oe;
    logic          en;
    logic [7:0]    sio;
    logic [7:0]    rd;
    logic          v;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t tab[int];
  exp_t steady, rst_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   rd_idx = 0;

  logic [3:0] c0mem [2] = '{4'h5, 4'h6};
  logic [3:0] c1mem [2] = '{4'h9, 4'hA};

  function automatic exp_t mk(input logic cs_n, input logic oe, input logic en,
                              input logic [7:0] sio, input logic [7:0] rd, input logic v,
                              input logic b, input logic d, input logic [CW-1:0] cnt);
    exp_t e;
    e.cs_n = cs_n; e.oe = oe; e.en = en; e.sio = sio; e.rd = rd;
    e.v = v; e.busy = b; e.done = d; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t actual();
    return mk(sram_cs_n, sio_oe, sram_clk_en, sio_out, rd_data, rd_valid, busy, cap_done,
              sample_count);
  endfunction

  function automatic logic [7:0] samp(input int k);
    return 8'(8'hA1 + 17 * k);
  endfunction

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    exp_t e, a;
    e = tab.exists(cyc) ? tab[cyc] : steady;
    a = actual();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL pins cyc%0d: got cs_n=%b oe=%b en=%b sio=%h rd=%h v=%b busy=%b done=%b cnt=%0d; want cs_n=%b oe=%b en=%b sio=%h rd=%h v=%b busy=%b done=%b cnt=%0d",
               cyc, a.cs_n, a.oe, a.en, a.sio, a.rd, a.v, a.busy, a.done, a.cnt,
               e.cs_n, e.oe, e.en, e.sio, e.rd, e.v, e.busy, e.done, e.cnt);
    end
  end

  // SRAM pair in SQI read mode: two dummy clocks, then one nibble per chip per gated clock.
  int dcnt = 0;
  int ptr = 0;
  always @(negedge clock) begin
    if (sram_cs_n) begin
      dcnt = 0; ptr = 0; sio_in = 8'hEE;
    end else if (sram_clk_en && !sio_oe) begin
      if (dcnt < 2) begin
        dcnt++; sio_in = 8'hEE;
      end else if (ptr < 2) begin
        sio_in = {c1mem[ptr], c0mem[ptr]}; ptr++;
      end else begin
        sio_in = 8'hEE;
      end
    end else begin
      sio_in = 8'hEE;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // mode 0: run to completion; 1: abort when sample_count==at_n; 2: reset_n low there.
  task automatic capture(input int lim, input int mode, input int at_n, input bit stray,
                         input bit both);
    int   c0, last, a, k;
    exp_t e, old;
    c0 = cyc; old = steady;
    tab[c0] = old;
    e = mk(1'b0, 1'b1, 1'b1, 8'h00, old.rd, 1'b0, 1'b1, 1'b0, '0);
    tab[c0+1] = e;
    e.sio = 8'h22; tab[c0+2] = e;
    e.sio = 8'h00;
    for (int i = 3; i <= 8; i++) tab[c0+i] = e;
    for (int j = 0; j <= lim; j++) begin
      e.sio = samp(j); e.cnt = CW'(j + 1); tab[c0+9+j] = e;
    end
    tab[c0+10+lim] = mk(1'b1, 1'b0, 1'b0, 8'h00, old.rd, 1'b0, 1'b1, 1'b1, CW'(lim + 1));
    steady = mk(1'b1, 1'b0, 1'b0, 8'h00, old.rd, 1'b0, 1'b0, 1'b1, CW'(lim + 1));
    last = c0 + 11 + lim;
    a = c0 + 8 + at_n;
    if (mode == 1) begin
      for (int c = a + 1; c <= last; c++) tab.delete(c);
      steady = mk(1'b1, 1'b0, 1'b0, 8'h00, old.rd, 1'b0, 1'b0, 1'b0, CW'(at_n));
      last = a + 1;
    end
    cap_start = 1'b1; rd_start = both; samples_post = CW'(lim); la_data = 8'h5A;
    tick();
    cap_start = 1'b0; rd_start = 1'b0; samples_post = CW'(7);
    for (int c = c0 + 1; c < last; c++) begin
      k = c + 1 - c0 - 9;
      la_data = (k >= 0 && k <= lim) ? samp(k) : 8'h5A;
      cap_start = stray && (c == c0 + 9);
      abort = (mode == 1) && (c == a);
      if (mode == 2 && c == a) begin
        #2; reset_n = 1'b0; #1;
        check("async_reset", 64'(actual()), 64'(rst_e));
        tab.delete();
        steady = rst_e;
        cap_start = 1'b0; la_data = 8'h5A;
        tick(); tick();
        reset_n = 1'b1;
        return;
      end
      tick();
    end
    cap_start = 1'b0; abort = 1'b0; la_data = 8'h5A;
  endtask

  task automatic readback(input bit stray);
    int   c0;
    exp_t e, old;
    c0 = cyc; old = steady; rd_idx = 0;
    tab[c0] = old;
    e = mk(1'b0, 1'b1, 1'b1, 8'h00, old.rd, 1'b0, 1'b1, 1'b0, old.cnt);
    tab[c0+1] = e;
    e.sio = 8'h33; tab[c0+2] = e;
    e.sio = 8'h00;
    for (int i = 3; i <= 8; i++) tab[c0+i] = e;
    e.oe = 1'b0; tab[c0+9] = e; tab[c0+10] = e;
    e.en = 1'b0; steady = e;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    for (int c = c0 + 1; c < c0 + 11; c++) begin
      rd_step = stray && (c == c0 + 4 || c == c0 + 9);
      tick();
    end
    rd_step = 1'b0;
  endtask

  task automatic step(input bit hold);
    int   s;
    exp_t e;
    s = cyc;
    tab[s] = steady;
    e = steady; e.en = 1'b1; tab[s+1] = e;
    e.en = 1'b0; e.v = 1'b1; e.rd = {c1mem[rd_idx], c0mem[rd_idx]}; tab[s+2] = e;
    e.v = 1'b0; steady = e;
    rd_idx++;
    rd_step = 1'b1; tick();
    rd_step = hold; tick(); tick();
    rd_step = 1'b0;
  endtask

  task automatic abort_now();
    exp_t e;
    if (!tab.exists(cyc)) tab[cyc] = steady;
    e = steady;
    e.cs_n = 1'b1; e.oe = 1'b0; e.en = 1'b0; e.sio = 8'h00; e.v = 1'b0; e.busy = 1'b0;
    steady = e;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    cap_start = 1'b0; rd_start = 1'b0; rd_step = 1'b0; abort = 1'b0;
    samples_post = '0; la_data = 8'h5A;
    rst_e = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    steady = rst_e;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check("reset_state", 64'(actual()), 64'(rst_e));
    rd_step = 1'b1; tick(); rd_step = 1'b0;
    repeat (9) tick();

    capture(3, 0, 0, 1'b1, 1'b0);
    check("cap4_count", 64'(sample_count), 64'd4);
    check("cap4_done", 64'(cap_done), 64'd1);
    repeat (3) tick();

    capture(0, 0, 0, 1'b0, 1'b1);
    check("cap1_count", 64'(sample_count), 64'd1);
    repeat (2) tick();

    tab[cyc] = steady;
    abort = 1'b1; cap_start = 1'b1; rd_start = 1'b1; tick();
    abort = 1'b0; cap_start = 1'b0; rd_start = 1'b0;
    repeat (3) tick();

    readback(1'b1);
    cap_start = 1'b1; tick(); cap_start = 1'b0;
    tick();
    step(1'b0);
    check("rd_byte0", 64'(rd_data), 64'h95);
    tick();
    step(1'b1);
    check("rd_byte1", 64'(rd_data), 64'hA6);
    repeat (3) tick();
    abort_now();
    repeat (2) tick();

    capture(100, 1, 2, 1'b0, 1'b0);
    check("abort_count", 64'(sample_count), 64'd2);
    check("abort_done", 64'(cap_done), 64'd0);
    tick();
    capture(2, 0, 0, 1'b0, 1'b0);
    repeat (2) tick();

    capture(20, 2, 5, 1'b0, 1'b0);
    repeat (3) tick();
    capture(1, 0, 0, 1'b0, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
